// File: rtl/pool_window_gather.sv
// rtl/pool_window_gather.sv - gathers raster pixels into packed 2x2 windows for max pooling
module pool_window_gather #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_W-1:0]   out_window,
  output logic                  out_last
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] linebuf [IMG_WIDTH];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] top_left;
  logic [DATA_W-1:0] b0;
  logic              xfer;
  logic              odd_row;
  logic              odd_col;
  logic              lb_wr;

  // A pending window blocks input only until downstream takes it
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign odd_row  = row[0];
  assign odd_col  = col[0];

  // Single read port: at an even column of an odd row it fetches the future
  // top-left, at the odd column it supplies the top-right directly
  assign rd_data  = linebuf[col];

  // Flush wins over a simultaneous transfer, so no write happens then either
  assign lb_wr    = xfer && !flush && !odd_row;

  // Line buffer holds the even (top) row; contents need no reset
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      linebuf[col] <= in_data;
    end
  end

  // Position counters, bottom-row hold registers and registered window output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      b0         <= '0;
      top_left   <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_last   <= 1'b0;
    end else if (flush) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (odd_row) begin
          if (!odd_col) begin
            b0       <= in_data;
            top_left <= rd_data;
          end else begin
            out_window <= {in_data, b0, rd_data, top_left};
            out_valid  <= 1'b1;
            out_last   <= (row == ROW_LAST) && (col == COL_LAST);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_gather.sv
// tb/tb_pool_window_gather.sv - randomized and directed check of pool_window_gather against a window model
module tb_pool_window_gather;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [4*DW-1:0] out_window;
  logic            out_last;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   pix [W*H];
  int              pos;
  logic [4*DW-1:0] qw[$];
  logic            ql[$];
  int              wins;
  logic            accepted;

  pool_window_gather #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pos  = 0;
    wins = 0;
    qw.delete();
    ql.delete();
  endtask

  // Frame is a flat array in raster order; a window completes at every odd row, odd column
  task automatic model_pixel(input logic [DW-1:0] d);
    int r;
    int c;
    pix[pos] = d;
    r = pos / W;
    c = pos % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      qw.push_back({d, pix[pos-1], pix[pos-W], pix[pos-W-1]});
      ql.push_back(pos == W*H-1);
    end
    pos = (pos + 1) % (W*H);
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic exp_valid;
    logic drain;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    exp_valid = (qw.size() != 0);
    chk("out_valid", 128'(out_valid), 128'(exp_valid));
    chk("in_ready", 128'(in_ready), 128'(!exp_valid || r));
    if (exp_valid) begin
      chk("out_window", out_window, qw[0]);
      chk("out_last", 128'(out_last), 128'(ql[0]));
    end
    accepted = v && (!exp_valid || r) && !f;
    drain    = exp_valid && r;
    if (f) begin
      model_clear();
    end else begin
      if (drain) begin
        wins++;
        if (ql[0]) begin
          chk("frame_wins", 128'(wins), 128'(W*H/4));
          wins = 0;
        end
        void'(qw.pop_front());
        void'(ql.pop_front());
      end
      if (accepted) model_pixel(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic r);
    int n = 0;
    accepted = 1'b0;
    while (!accepted && n < 50) begin
      cycle(1'b1, d, r, 1'b0);
      n++;
    end
    chk("send_timeout", 128'(accepted), 128'(1));
  endtask

  task automatic send_rand(input logic [DW-1:0] d);
    int n = 0;
    accepted = 1'b0;
    while (!accepted && n < 200) begin
      cycle(1'($urandom_range(1)), d, 1'($urandom_range(3) != 0), 1'b0);
      n++;
    end
    chk("send_rand_timeout", 128'(accepted), 128'(1));
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, r, 1'b0);
  endtask

  initial begin
    logic signed [DW-1:0] m;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_clear();
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_window", out_window, 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ascending frame, always ready
    for (int k = 0; k < 16; k++) begin
      send(32'(k), 1'b1);
      if (k == 5) begin
        chk("t1_lat", 128'(out_valid), 128'(1));
        chk("t1_w0", out_window, {32'd5, 32'd4, 32'd1, 32'd0});
      end
    end
    idle(2, 1'b1);

    // Negative pixels pass bit-exact; downstream max of window 0 is zero
    for (int k = 0; k < 16; k++) begin
      send(32'(-k), 1'b1);
      if (k == 5) begin
        chk("t2_w0", out_window, {32'hFFFFFFFB, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000000});
        m = out_window[DW-1:0];
        for (int l = 1; l < 4; l++)
          if ($signed(out_window[l*DW +: DW]) > m) m = out_window[l*DW +: DW];
        chk("t2_max", {96'b0, m}, 128'(0));
      end
    end
    idle(2, 1'b1);

    // Downstream stall for 5 cycles after window 0
    for (int k = 0; k < 6; k++) send(32'(k), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'd6, 1'b0, 1'b0);
      chk("t3_stall_in_ready", 128'(in_ready), 128'(0));
    end
    for (int k = 6; k < 16; k++) send(32'(k), 1'b1);
    idle(2, 1'b1);

    // Two frames back to back
    for (int k = 0; k < 16; k++) send(32'(k), 1'b1);
    for (int k = 100; k < 116; k++) begin
      send(32'(k), 1'b1);
      if (k == 105) chk("t4_f2w0", out_window, {32'd105, 32'd104, 32'd101, 32'd100});
    end
    idle(2, 1'b1);

    // Flush with a pending window and a presented pixel
    for (int k = 0; k < 6; k++) send(32'(k), 1'b0);
    cycle(1'b1, 32'd6, 1'b0, 1'b1);
    chk("t5_flush_valid", 128'(out_valid), 128'(0));
    for (int k = 0; k < 16; k++) send(32'(k), 1'b1);
    idle(2, 1'b1);

    // Asynchronous reset mid row 1 with a window pending
    for (int k = 0; k < 6; k++) send(32'(k), 1'b0);
    #3;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 128'(out_valid), 128'(0));
    chk("t6_rst_out_window", out_window, 128'(0));
    chk("t6_rst_out_last", 128'(out_last), 128'(0));
    chk("t6_rst_in_ready", 128'(in_ready), 128'(1));
    #10;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) send(32'(k), 1'b1);
    idle(2, 1'b1);

    // Random data with random valid/ready over several frames
    for (int i = 0; i < 4*W*H; i++) send_rand($urandom);
    idle(3, 1'b1);
    chk("drain_empty", 128'(qw.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
